// File: rtl/ram_bist_pkg.sv
// Shared types for the March C- BIST RAM: FSM states, march elements, per-element ops
// and the bit layout of the packed tst_out status byte.
package ram_bist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef enum logic [2:0] {
    EL_W0      = 3'd0,
    EL_R0W1    = 3'd1,
    EL_R1W0    = 3'd2,
    EL_DN_R0W1 = 3'd3,
    EL_DN_R1W0 = 3'd4,
    EL_R0      = 3'd5
  } elem_e;

  typedef enum logic [2:0] {OP_R0, OP_R1, OP_W0, OP_W1, OP_NOP} op_e;

  localparam int TST_BUSY     = 7;
  localparam int TST_DONE     = 6;
  localparam int TST_PASS     = 5;
  localparam int TST_ELEM_LSB = 2;
  localparam int TST_ERR_LSB  = 0;

  function automatic op_e elem_rd_op(elem_e e);
    case (e)
      EL_R0W1, EL_DN_R0W1, EL_R0: return OP_R0;
      EL_R1W0, EL_DN_R1W0:        return OP_R1;
      default:                    return OP_NOP;
    endcase
  endfunction

  function automatic op_e elem_wr_op(elem_e e);
    case (e)
      EL_W0, EL_R1W0, EL_DN_R1W0: return OP_W0;
      EL_R0W1, EL_DN_R0W1:        return OP_W1;
      default:                    return OP_NOP;
    endcase
  endfunction

  function automatic logic elem_is_down(elem_e e);
    return (e == EL_DN_R0W1) || (e == EL_DN_R1W0);
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// Functional RAM port, BIST control/status and fault-injection signals of ram_march_bist.
// button is a level; the engine starts on its rising edge when not busy (no handshake back).
interface ram_bist_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] wrt_addrs;
  logic [ADDR_W-1:0] rd_addrs;
  logic [DATA_W-1:0] wrt_dat;
  logic              wrt_en;
  logic              button;
  logic              inj_en;
  logic [ADDR_W-1:0] inj_addr;
  logic [DATA_W-1:0] rd_dat;
  logic              bist_busy;
  logic              bist_done;
  logic              bist_pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [7:0]        tst_out;
  logic [1:0]        dbg_state;

  modport master (
    output wrt_addrs, rd_addrs, wrt_dat, wrt_en, button, inj_en, inj_addr,
    input  rd_dat, bist_busy, bist_done, bist_pass, fail_addr, tst_out, dbg_state
  );

  modport slave (
    input  wrt_addrs, rd_addrs, wrt_dat, wrt_en, button, inj_en, inj_addr,
    output rd_dat, bist_busy, bist_done, bist_pass, fail_addr, tst_out, dbg_state
  );
endinterface

// File: rtl/ram_dp_sync.sv
// Simple dual-port RAM: synchronous write, registered read returning pre-write data.
module ram_dp_sync #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage itself has no reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/ram_march_bist.sv
// Dual-port RAM with a March C- self-test engine that takes over both ports while busy.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              ADDR_W       = 10,
  parameter logic [DATA_W-1:0] BG_PAT     = '0,
  parameter bit              STOP_ON_FAIL = 1'b1
) (
  input logic     clk,
  input logic     rst,
  ram_bist_if.slave bus
);
  state_e            state_q, state_d;
  elem_e             elem_q, elem_d;
  logic              phase_q, phase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              btn_q, btn_d;
  logic              inj_hit_q, inj_hit_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;
  logic [1:0]        err_cnt_q, err_cnt_d;

  logic              busy, done, pass, start;
  logic              has_read, step_last, mismatch;
  op_e               rd_op, wr_op;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, rd_seen, exp_dat;
  logic [ADDR_W-1:0] last_addr;

  ram_dp_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk), .rst(rst), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata),
    .raddr(ram_raddr), .rdata(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= EL_W0;
      phase_q     <= 1'b0;
      addr_q      <= '0;
      btn_q       <= 1'b0;
      inj_hit_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      btn_q       <= btn_d;
      inj_hit_q   <= inj_hit_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Datapath decode shared by next-state and port muxing.
  always_comb begin
    rd_op     = elem_rd_op(elem_q);
    wr_op     = elem_wr_op(elem_q);
    has_read  = (rd_op != OP_NOP);
    exp_dat   = (rd_op == OP_R1) ? ~BG_PAT : BG_PAT;
    rd_seen   = {ram_rdata[DATA_W-1:1], ram_rdata[0] & ~inj_hit_q};
    last_addr = elem_is_down(elem_q) ? '0 : '1;
    step_last = !has_read || phase_q;
    mismatch  = busy && has_read && phase_q && (rd_seen != exp_dat);
    start     = bus.button && !btn_q && !busy;
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    err_cnt_d   = err_cnt_q;
    if (start) begin
      state_d     = ST_RUN;
      elem_d      = EL_W0;
      phase_d     = 1'b0;
      addr_d      = '0;
      fail_addr_d = '0;
      fail_elem_d = '0;
      err_cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      if (mismatch) begin
        if (err_cnt_q == 2'd0) begin
          fail_addr_d = addr_q;
          fail_elem_d = elem_q;
        end
        if (err_cnt_q != 2'd3) err_cnt_d = err_cnt_q + 2'd1;
      end
      if (mismatch && STOP_ON_FAIL) begin
        state_d = ST_DONE;
      end else if (!step_last) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (addr_q == last_addr) begin
          if (elem_q == EL_R0) begin
            state_d = ST_DONE;
          end else begin
            elem_d = elem_e'(elem_q + 3'd1);
            addr_d = elem_is_down(elem_d) ? '1 : '0;
          end
        end else begin
          addr_d = elem_is_down(elem_q) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
      end
    end
  end

  always_comb begin
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    pass      = done && (err_cnt_q == 2'd0);
    btn_d     = bus.button;
    ram_raddr = busy ? addr_q : bus.rd_addrs;
    inj_hit_d = bus.inj_en && (ram_raddr == bus.inj_addr);
    if (busy) begin
      ram_we    = step_last && (wr_op != OP_NOP);
      ram_waddr = addr_q;
      ram_wdata = (wr_op == OP_W1) ? ~BG_PAT : BG_PAT;
    end else begin
      ram_we    = bus.wrt_en;
      ram_waddr = bus.wrt_addrs;
      ram_wdata = bus.wrt_dat;
    end
  end

  always_comb begin
    bus.tst_out                         = '0;
    bus.tst_out[TST_BUSY]               = busy;
    bus.tst_out[TST_DONE]               = done;
    bus.tst_out[TST_PASS]               = pass;
    bus.tst_out[TST_ELEM_LSB +: 3]      = fail_elem_q;
    bus.tst_out[TST_ERR_LSB +: 2]       = err_cnt_q;
  end

  assign bus.rd_dat    = busy ? '0 : rd_seen;
  assign bus.bist_busy = busy;
  assign bus.bist_done = done;
  assign bus.bist_pass = pass;
  assign bus.fail_addr = fail_addr_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench: two instances (stop-on-fail and run-to-completion) driven in parallel.
module tb_ram_march_bist;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] wrt_addrs = '0;
  logic [AW-1:0] rd_addrs = '0;
  logic [DW-1:0] wrt_dat = '0;
  logic          wrt_en = 1'b0;
  logic          button = 1'b0;
  logic          inj_en = 1'b0;
  logic [AW-1:0] inj_addr = '0;

  int checks = 0;
  int errors = 0;

  ram_bist_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
  ram_bist_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

  assign if_a.wrt_addrs = wrt_addrs;  assign if_b.wrt_addrs = wrt_addrs;
  assign if_a.rd_addrs  = rd_addrs;   assign if_b.rd_addrs  = rd_addrs;
  assign if_a.wrt_dat   = wrt_dat;    assign if_b.wrt_dat   = wrt_dat;
  assign if_a.wrt_en    = wrt_en;     assign if_b.wrt_en    = wrt_en;
  assign if_a.button    = button;     assign if_b.button    = button;
  assign if_a.inj_en    = inj_en;     assign if_b.inj_en    = inj_en;
  assign if_a.inj_addr  = inj_addr;   assign if_b.inj_addr  = inj_addr;

  ram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .BG_PAT(8'h00), .STOP_ON_FAIL(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(if_a));
  ram_march_bist #(.DATA_W(DW), .ADDR_W(AW), .BG_PAT(8'h00), .STOP_ON_FAIL(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b));

  // Clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start a run and count busy cycles on both instances. Optionally re-toggles
  // button at cycle glitch_at and samples rd_dat at cycle 20.
  task automatic run_bist(input int glitch_at, input bit hold_btn,
                          output int cyc_a, output int cyc_b);
    bit fin;
    cyc_a = 0;
    cyc_b = 0;
    fin = 1'b0;
    @(negedge clk);
    button = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (if_a.bist_busy) cyc_a++;
      if (if_b.bist_busy) cyc_b++;
      if (i == glitch_at) button = 1'b0;
      if (i == glitch_at + 1) button = 1'b1;
      if (i == 20) begin
        checks++;
        if (if_a.rd_dat !== 8'h00) begin
          errors++;
          $display("FAIL rd_dat_busy: got %h want 00", if_a.rd_dat);
        end
      end
      if (if_a.bist_done && if_b.bist_done) begin
        fin = 1'b1;
        break;
      end
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL run_timeout: done_a=%b done_b=%b want both 1", if_a.bist_done, if_b.bist_done);
    end
    if (!hold_btn) button = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({if_a.bist_busy, if_a.bist_done, if_a.bist_pass, if_a.fail_addr, if_a.tst_out, if_a.rd_dat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b fa=%h tst=%h rd=%h want all 0",
               if_a.bist_busy, if_a.bist_done, if_a.bist_pass, if_a.fail_addr, if_a.tst_out, if_a.rd_dat);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (if_b.tst_out !== 8'h00 || if_a.dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: got tst=%h state=%0d want 00 / 0", if_b.tst_out, if_a.dbg_state);
    end
  endtask

  task automatic test_functional();
    wrt_en = 1'b1; wrt_addrs = 4'd3; wrt_dat = 8'hA5;
    @(negedge clk);
    wrt_en = 1'b0; rd_addrs = 4'd3;
    @(negedge clk);
    checks++;
    if (if_a.rd_dat !== 8'hA5) begin
      errors++;
      $display("FAIL func_read: got %h want a5", if_a.rd_dat);
    end
    // Same-address collision: the read sees the old word.
    wrt_en = 1'b1; wrt_dat = 8'h3C;
    @(negedge clk);
    wrt_en = 1'b0;
    checks++;
    if (if_a.rd_dat !== 8'hA5) begin
      errors++;
      $display("FAIL rw_collision: got %h want a5", if_a.rd_dat);
    end
    @(negedge clk);
    checks++;
    if (if_a.rd_dat !== 8'h3C) begin
      errors++;
      $display("FAIL read_new: got %h want 3c", if_a.rd_dat);
    end
    wrt_en = 1'b1; wrt_addrs = 4'd5; wrt_dat = 8'h5B; rd_addrs = 4'd5;
    inj_en = 1'b1; inj_addr = 4'd5;
    @(negedge clk);
    wrt_en = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.rd_dat !== 8'h5A) begin
      errors++;
      $display("FAIL func_inject: got %h want 5a", if_a.rd_dat);
    end
    inj_en = 1'b0;
    @(negedge clk);
    checks++;
    if (if_a.rd_dat !== 8'h5B) begin
      errors++;
      $display("FAIL inject_storage: got %h want 5b", if_a.rd_dat);
    end
  endtask

  task automatic test_clean_run();
    int ca, cb;
    run_bist(-5, 1'b0, ca, cb);
    checks++;
    if (ca !== 176 || cb !== 176) begin
      errors++;
      $display("FAIL clean_cycles: got a=%0d b=%0d want 176", ca, cb);
    end
    checks++;
    if (if_a.tst_out !== 8'h60 || if_b.tst_out !== 8'h60) begin
      errors++;
      $display("FAIL clean_tst: got a=%h b=%h want 60", if_a.tst_out, if_b.tst_out);
    end
    checks++;
    if (if_a.bist_pass !== 1'b1 || if_a.fail_addr !== 4'd0) begin
      errors++;
      $display("FAIL clean_pass: got pass=%b fa=%h want 1 / 0", if_a.bist_pass, if_a.fail_addr);
    end
  endtask

  task automatic test_fault();
    int ca, cb;
    inj_en = 1'b1; inj_addr = 4'd9;
    run_bist(-5, 1'b0, ca, cb);
    inj_en = 1'b0;
    checks++;
    if (ca !== 68 || cb !== 176) begin
      errors++;
      $display("FAIL fault_cycles: got a=%0d b=%0d want 68 / 176", ca, cb);
    end
    checks++;
    if (if_a.tst_out !== 8'h49 || if_a.fail_addr !== 4'd9 || if_a.bist_pass !== 1'b0) begin
      errors++;
      $display("FAIL stop_result: got tst=%h fa=%h pass=%b want 49 / 9 / 0",
               if_a.tst_out, if_a.fail_addr, if_a.bist_pass);
    end
    checks++;
    if (if_b.tst_out !== 8'h4A || if_b.fail_addr !== 4'd9 || if_b.bist_pass !== 1'b0) begin
      errors++;
      $display("FAIL full_result: got tst=%h fa=%h pass=%b want 4a / 9 / 0",
               if_b.tst_out, if_b.fail_addr, if_b.bist_pass);
    end
  endtask

  task automatic test_button_mid_run();
    int ca, cb;
    run_bist(80, 1'b1, ca, cb);
    checks++;
    if (ca !== 176 || cb !== 176) begin
      errors++;
      $display("FAIL retrigger_cycles: got a=%0d b=%0d want 176", ca, cb);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (if_a.bist_busy !== 1'b0 || if_a.tst_out !== 8'h60) begin
      errors++;
      $display("FAIL held_button: got busy=%b tst=%h want 0 / 60", if_a.bist_busy, if_a.tst_out);
    end
    button = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int ca, cb;
    @(negedge clk);
    button = 1'b1;
    repeat (50) @(negedge clk);
    checks++;
    if (if_a.bist_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_rst: got %b want 1", if_a.bist_busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if_a.tst_out !== 8'h00 || if_b.tst_out !== 8'h00 || if_a.fail_addr !== 4'd0) begin
      errors++;
      $display("FAIL async_abort: got a=%h b=%h fa=%h want 00", if_a.tst_out, if_b.tst_out, if_a.fail_addr);
    end
    button = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_bist(-5, 1'b0, ca, cb);
    checks++;
    if (ca !== 176 || if_a.tst_out !== 8'h60 || if_b.tst_out !== 8'h60) begin
      errors++;
      $display("FAIL rerun_after_rst: got cyc=%0d a=%h b=%h want 176 / 60", ca, if_a.tst_out, if_b.tst_out);
    end
  endtask

  initial begin
    test_reset();
    test_functional();
    test_clean_run();
    test_fault();
    test_button_mid_run();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
